// File: rtl/led_pulse_stretcher_pkg.sv
// -----------------------------------------------------------------------------
// led_pulse_stretcher_pkg
//
// Purpose : Shared constants for the LED pulse stretcher and its neighbours:
//           FSM state encodings, the board clock rate and a milliseconds to
//           clock cycles helper used to derive the default flash timing.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package led_pulse_stretcher_pkg;

  // FSM state encodings. These are plain constants rather than an enum so that
  // older tools and neighbouring modules can share the same encoding directly.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Board clock.
  localparam int unsigned C_CLK_HZ = 25_000_000;

  // Milliseconds to clock cycles at the board clock rate.
  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return (C_CLK_HZ / 1000) * ms;
  endfunction

  // Default flash length and off gap: 10 ms each.
  localparam int unsigned C_10MS_CYCLES = ms_to_cycles(10);

  // Larger of two unsigned values, used for sizing the shared ON/GAP timer.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage : led_pulse_stretcher_pkg

// File: rtl/rise_detect.sv
// -----------------------------------------------------------------------------
// rise_detect
//
// Purpose : Single-cycle rising-edge detector. o_Rise is high during the cycle
//           in which i_Sig is 1 and was 0 on the previous clock. A level held
//           high yields exactly one pulse. Reusable by any button or event
//           consumer that needs a one-shot per 0->1 transition.
// Ports   :
//   i_Clk    in  1  clock
//   i_Reset  in  1  synchronous, active-high reset (clears the history flop)
//   i_Sig    in  1  level to watch
//   o_Rise   out 1  combinational rising-edge strobe
// -----------------------------------------------------------------------------
module rise_detect (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Sig,
  output logic o_Rise
);

  logic sig_prev_q;
  logic sig_prev_d;

  always_comb begin
    sig_prev_d = i_Sig;
  end

  // NOTE: flops are written with non-blocking (<=) so every register samples
  // the pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      sig_prev_q <= 1'b0;
    end else begin
      sig_prev_q <= sig_prev_d;
    end
  end

  // Clearing the history on reset means an input already high when reset
  // releases counts as a fresh edge.
  assign o_Rise = i_Sig & ~sig_prev_q;

endmodule : rise_detect

// File: rtl/led_pulse_stretcher.sv
// -----------------------------------------------------------------------------
// led_pulse_stretcher
//
// Purpose : Turns single-cycle internal events into human-visible LED flashes.
//           Each flash drives the LED high for c_ON_CYCLES clocks and is
//           followed by a forced low gap of c_OFF_CYCLES clocks. Events that
//           arrive while a flash or gap is in progress are counted (up to
//           c_PENDING_MAX) and replayed as separate flashes; events beyond
//           that are dropped and flagged on o_Drop.
//
// Parameters:
//   c_ON_CYCLES    LED high time per flash, in clocks (>= 1)
//   c_OFF_CYCLES   forced LED low gap after each flash, in clocks (>= 1)
//   c_PENDING_MAX  maximum number of queued flashes (>= 1)
//
// Ports   :
//   i_Clk      in  1  system clock (25 MHz board clock)
//   i_Reset    in  1  synchronous, active-high reset
//   i_Pulse    in  1  event input; every 0->1 transition is one event
//   o_LED      out 1  stretched LED drive, registered
//   o_Busy     out 1  high while in the ON or GAP state
//   o_Pending  out W  queued flash count, W = $clog2(c_PENDING_MAX+1)
//   o_Drop     out 1  one-cycle pulse when an event is discarded (queue full)
//
// Build option:
//   LED_PULSE_STRETCH_RETRIGGER_EN
//     defined   : an event during ON restarts the ON timer (the flash is
//                 extended rather than queued); events during GAP still queue.
//     undefined : every event during ON or GAP queues (default build).
// -----------------------------------------------------------------------------
module led_pulse_stretcher
  import led_pulse_stretcher_pkg::*;
#(
  parameter int unsigned c_ON_CYCLES   = C_10MS_CYCLES,
  parameter int unsigned c_OFF_CYCLES  = C_10MS_CYCLES,
  parameter int unsigned c_PENDING_MAX = 7
) (
  input  logic                                 i_Clk,
  input  logic                                 i_Reset,
  input  logic                                 i_Pulse,
  output logic                                 o_LED,
  output logic                                 o_Busy,
  output logic [$clog2(c_PENDING_MAX+1)-1:0]   o_Pending,
  output logic                                 o_Drop
);

  // One timer is shared by ON and GAP, so it must hold the larger count.
  localparam int unsigned TIMER_W = $clog2(max_u(c_ON_CYCLES, c_OFF_CYCLES) + 1);
  localparam int unsigned PEND_W  = $clog2(c_PENDING_MAX + 1);

  localparam logic [TIMER_W-1:0] ON_LAST   = TIMER_W'(c_ON_CYCLES - 1);
  localparam logic [TIMER_W-1:0] OFF_LAST  = TIMER_W'(c_OFF_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);
  localparam logic [PEND_W-1:0]  PEND_MAX  = PEND_W'(c_PENDING_MAX);
  localparam logic [PEND_W-1:0]  PEND_ONE  = PEND_W'(1);

  // ---------------------------------------------------------------------------
  // Event detection
  // ---------------------------------------------------------------------------
  logic ev;

  rise_detect u_rise_detect (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_Sig   (i_Pulse),
    .o_Rise  (ev)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]         state_q,   state_d;
  logic [TIMER_W-1:0] timer_q,   timer_d;
  logic [PEND_W-1:0]  pending_q, pending_d;
  logic               led_q,     led_d;
  logic               busy_q,    busy_d;
  logic               drop_q,    drop_d;

  logic on_last;
  logic gap_last;
  logic pend_full;
  logic pend_empty;

  assign on_last    = (timer_q == ON_LAST);
  assign gap_last   = (timer_q == OFF_LAST);
  assign pend_full  = (pending_q == PEND_MAX);
  assign pend_empty = (pending_q == '0);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable assigned below gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    timer_d   = timer_q;
    pending_d = pending_q;
    drop_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ev) begin
          state_d = ST_ON;
          timer_d = '0;
        end
      end

      ST_ON: begin
`ifdef LED_PULSE_STRETCH_RETRIGGER_EN
        // A new event stretches the current flash instead of queueing one.
        if (ev) begin
          timer_d = '0;
        end else if (on_last) begin
          state_d = ST_GAP;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
`else
        if (ev) begin
          if (pend_full) begin
            drop_d = 1'b1;
          end else begin
            pending_d = pending_q + PEND_ONE;
          end
        end
        if (on_last) begin
          state_d = ST_GAP;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
`endif
      end

      ST_GAP: begin
        if (gap_last) begin
          timer_d = '0;
          if (!pend_empty) begin
            // Replay one queued flash. An event landing on this same cycle
            // takes the freed slot, so the count is left unchanged.
            state_d = ST_ON;
            if (!ev) begin
              pending_d = pending_q - PEND_ONE;
            end
          end else if (ev) begin
            // Nothing queued: the coincident event starts the next flash
            // directly and never touches the queue.
            state_d = ST_ON;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q + TIMER_ONE;
          if (ev) begin
            if (pend_full) begin
              drop_d = 1'b1;
            end else begin
              pending_d = pending_q + PEND_ONE;
            end
          end
        end
      end

      default: begin
        // Unreachable encoding: recover to a clean idle.
        state_d   = ST_IDLE;
        timer_d   = '0;
        pending_d = '0;
      end
    endcase

    // Outputs are registered from the next state so the LED rises on the same
    // edge that samples the rising event.
    led_d  = (state_d == ST_ON);
    busy_d = (state_d != ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      pending_q <= '0;
      led_q     <= 1'b0;
      busy_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
      drop_q    <= drop_d;
    end
  end

  assign o_LED     = led_q;
  assign o_Busy    = busy_q;
  assign o_Pending = pending_q;
  assign o_Drop    = drop_q;

endmodule : led_pulse_stretcher

// File: tb/tb_led_pulse_stretcher.sv
// -----------------------------------------------------------------------------
// tb_led_pulse_stretcher
//
// Directed bench for led_pulse_stretcher with c_ON_CYCLES=4, c_OFF_CYCLES=3,
// c_PENDING_MAX=2. The stimulus process pushes hand-computed per-cycle
// expectations (LED, busy, pending, drop) into a scoreboard queue before it
// drives each scenario; a monitor pops and compares them on the falling edge
// of every cycle. Cycle numbers in the tables are relative to the start of
// each scenario: an input driven in cycle k is sampled by the edge that ends
// cycle k, so its effect shows from cycle k+1.
// -----------------------------------------------------------------------------
module tb_led_pulse_stretcher;

  localparam int ON_C  = 4;
  localparam int OFF_C = 3;
  localparam int PMAX  = 2;
  localparam int PW    = $clog2(PMAX + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          pulse;
  logic          led;
  logic          busy;
  logic [PW-1:0] pend;
  logic          drop;

  always #5 clk = ~clk;

  led_pulse_stretcher #(
    .c_ON_CYCLES   (ON_C),
    .c_OFF_CYCLES  (OFF_C),
    .c_PENDING_MAX (PMAX)
  ) dut (
    .i_Clk     (clk),
    .i_Reset   (rst),
    .i_Pulse   (pulse),
    .o_LED     (led),
    .o_Busy    (busy),
    .o_Pending (pend),
    .o_Drop    (drop)
  );

  typedef struct {
    int            cyc;
    string         nm;
    logic          led;
    logic          busy;
    logic [PW-1:0] pend;
    logic          drop;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   cyc    = 0;
  int   base   = 0;
  int   n_vec  = 0;
  int   n_bad  = 0;

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  function automatic logic [63:0] at(input int a);
    return 64'd1 << a;
  endfunction

  // Immediate comparison of one observed value against its expectation.
  task automatic check(input string nm, input logic [7:0] got,
                       input logic [7:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %0d, want %0d", nm, cyc, got, want);
    end
  endtask

  // Expect the same output tuple over relative cycles [from, to].
  task automatic expect_span(input string nm, input int from, input int to,
                             input logic l, input logic b, input int p,
                             input logic d);
    for (int c = from; c <= to; c++) begin
      exp_t e;
      e.cyc  = base + c;
      e.nm   = nm;
      e.led  = l;
      e.busy = b;
      e.pend = PW'(p);
      e.drop = d;
      sb.push_back(e);
    end
  endtask

  // Drive i_Pulse / i_Reset from bit masks for n cycles, then release both.
  task automatic run(input logic [63:0] pat, input logic [63:0] rpat, input int n);
    for (int k = 0; k < n; k++) begin
      pulse = pat[k];
      rst   = rpat[k];
      step();
    end
    pulse = 1'b0;
    rst   = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compare every scheduled expectation on the falling edge.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      m_e = sb.pop_front();
      n_vec++;
      if (m_e.cyc != cyc || led !== m_e.led || busy !== m_e.busy ||
          pend !== m_e.pend || drop !== m_e.drop) begin
        n_bad++;
        $display("FAIL %s cyc=%0d (want cyc %0d): got led=%b busy=%b pend=%0d drop=%b, want led=%b busy=%b pend=%0d drop=%b",
                 m_e.nm, cyc, m_e.cyc, led, busy, pend, drop,
                 m_e.led, m_e.busy, m_e.pend, m_e.drop);
      end
    end
  end

  // Hard stop in case something stalls the stimulus process.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  initial begin
    rst   = 1'b1;
    pulse = 1'b1;

    // Reset held two cycles with the input high: everything stays cleared.
    base = cyc;
    expect_span("reset", 1, 4, 0, 0, 0, 0);
    run(64'h3, 64'h3, 2);
    check("reset_led",  8'(led),  8'd0);
    check("reset_busy", 8'(busy), 8'd0);
    check("reset_pend", 8'(pend), 8'd0);
    check("reset_drop", 8'(drop), 8'd0);
    run(64'h0, 64'h0, 3);

    // Single one-cycle event: LED 1..4, busy 1..7, idle at 8.
    base = cyc;
    expect_span("single_idle", 0, 0, 0, 0, 0, 0);
    expect_span("single_on",   1, 4, 1, 1, 0, 0);
    expect_span("single_gap",  5, 7, 0, 1, 0, 0);
    expect_span("single_done", 8, 9, 0, 0, 0, 0);
    run(at(0), 64'h0, 10);

    // Input held high for 20 cycles: exactly one flash, nothing queued.
    base = cyc;
    expect_span("held_idle", 0, 0,  0, 0, 0, 0);
    expect_span("held_on",   1, 4,  1, 1, 0, 0);
    expect_span("held_gap",  5, 7,  0, 1, 0, 0);
    expect_span("held_done", 8, 21, 0, 0, 0, 0);
    run(at(20) - 64'd1, 64'h0, 22);

    // Queue: events at 2 and 4 queue, event at 6 hits a full queue and drops.
    base = cyc;
    expect_span("queue_idle",  0,  0,  0, 0, 0, 0);
    expect_span("queue_on1a",  1,  2,  1, 1, 0, 0);
    expect_span("queue_on1b",  3,  4,  1, 1, 1, 0);
    expect_span("queue_gap1",  5,  6,  0, 1, 2, 0);
    expect_span("queue_drop",  7,  7,  0, 1, 2, 1);
    expect_span("queue_on2",   8,  11, 1, 1, 1, 0);
    expect_span("queue_gap2",  12, 14, 0, 1, 1, 0);
    expect_span("queue_on3",   15, 18, 1, 1, 0, 0);
    expect_span("queue_gap3",  19, 21, 0, 1, 0, 0);
    expect_span("queue_done",  22, 22, 0, 0, 0, 0);
    run(at(0) | at(2) | at(4) | at(6), 64'h0, 23);

    // Event on the last GAP cycle with one queued: count stays 1.
    base = cyc;
    expect_span("coin1_idle", 0,  0,  0, 0, 0, 0);
    expect_span("coin1_on1a", 1,  2,  1, 1, 0, 0);
    expect_span("coin1_on1b", 3,  4,  1, 1, 1, 0);
    expect_span("coin1_gap1", 5,  7,  0, 1, 1, 0);
    expect_span("coin1_on2",  8,  11, 1, 1, 1, 0);
    expect_span("coin1_gap2", 12, 14, 0, 1, 1, 0);
    expect_span("coin1_on3",  15, 18, 1, 1, 0, 0);
    expect_span("coin1_gap3", 19, 21, 0, 1, 0, 0);
    expect_span("coin1_done", 22, 22, 0, 0, 0, 0);
    run(at(0) | at(2) | at(7), 64'h0, 23);

    // Event on the last GAP cycle with nothing queued: straight into ON.
    base = cyc;
    expect_span("coin0_idle", 0,  0,  0, 0, 0, 0);
    expect_span("coin0_on1",  1,  4,  1, 1, 0, 0);
    expect_span("coin0_gap1", 5,  7,  0, 1, 0, 0);
    expect_span("coin0_on2",  8,  11, 1, 1, 0, 0);
    expect_span("coin0_gap2", 12, 14, 0, 1, 0, 0);
    expect_span("coin0_done", 15, 15, 0, 0, 0, 0);
    run(at(0) | at(7), 64'h0, 16);

    // Event on the last GAP cycle with a full queue: no drop, count stays 2.
    base = cyc;
    expect_span("coin2_idle", 0,  0,  0, 0, 0, 0);
    expect_span("coin2_on1a", 1,  2,  1, 1, 0, 0);
    expect_span("coin2_on1b", 3,  4,  1, 1, 1, 0);
    expect_span("coin2_gap1", 5,  7,  0, 1, 2, 0);
    expect_span("coin2_on2",  8,  11, 1, 1, 2, 0);
    expect_span("coin2_gap2", 12, 14, 0, 1, 2, 0);
    expect_span("coin2_on3",  15, 18, 1, 1, 1, 0);
    expect_span("coin2_gap3", 19, 21, 0, 1, 1, 0);
    expect_span("coin2_on4",  22, 25, 1, 1, 0, 0);
    expect_span("coin2_gap4", 26, 28, 0, 1, 0, 0);
    expect_span("coin2_done", 29, 29, 0, 0, 0, 0);
    run(at(0) | at(2) | at(4) | at(7), 64'h0, 30);

    // Reset in the middle of ON with two queued: abort, no further flashes.
    base = cyc;
    expect_span("rstmid_idle", 0,  0,  0, 0, 0, 0);
    expect_span("rstmid_on1a", 1,  2,  1, 1, 0, 0);
    expect_span("rstmid_on1b", 3,  4,  1, 1, 1, 0);
    expect_span("rstmid_gap1", 5,  7,  0, 1, 2, 0);
    expect_span("rstmid_on2",  8,  9,  1, 1, 2, 0);
    expect_span("rstmid_post", 10, 20, 0, 0, 0, 0);
    run(at(0) | at(2) | at(4) | at(7), at(9), 21);

    // Event while ON timer == 2.
    base = cyc;
    expect_span("trig_idle", 0, 0, 0, 0, 0, 0);
`ifdef LED_PULSE_STRETCH_RETRIGGER_EN
    expect_span("trig_on",   1,  7,  1, 1, 0, 0);
    expect_span("trig_gap",  8,  10, 0, 1, 0, 0);
    expect_span("trig_done", 11, 15, 0, 0, 0, 0);
`else
    expect_span("trig_on1a", 1,  3,  1, 1, 0, 0);
    expect_span("trig_on1b", 4,  4,  1, 1, 1, 0);
    expect_span("trig_gap1", 5,  7,  0, 1, 1, 0);
    expect_span("trig_on2",  8,  11, 1, 1, 0, 0);
    expect_span("trig_gap2", 12, 14, 0, 1, 0, 0);
    expect_span("trig_done", 15, 15, 0, 0, 0, 0);
`endif
    run(at(0) | at(3), 64'h0, 16);

    // Let the monitor drain; anything left unchecked is a miscompare.
    step();
    step();
    while (sb.size() > 0) begin
      m_e = sb.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL %s: expectation for cyc %0d never checked (now cyc %0d)",
               m_e.nm, m_e.cyc, cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_led_pulse_stretcher
